// File: rtl/pipe_skid_reg.sv
// Generic pipeline-stage register: valid/ready handshake, synchronous flush,
// optional two-entry skid buffer so downstream stalls never reach in_ready_o.
module pipe_skid_reg #(
   parameter int               WIDTH     = 137,
   parameter int               SKID      = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_data_o,
   output logic [1:0]       occupancy_o
);

   logic             main_vld;
   logic             skid_vld;
   logic [WIDTH-1:0] main_data;
   logic [WIDTH-1:0] skid_data;
   logic             main_vld_n;
   logic             skid_vld_n;
   logic [WIDTH-1:0] main_data_n;
   logic [WIDTH-1:0] skid_data_n;
   logic             push;
   logic             pop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_vld  <= 1'b0;
         skid_vld  <= 1'b0;
         main_data <= RESET_VAL;
         skid_data <= RESET_VAL;
      end else begin
         main_vld  <= main_vld_n;
         skid_vld  <= skid_vld_n;
         main_data <= main_data_n;
         skid_data <= skid_data_n;
      end
   end

   // Flush only drops valid bits; the data registers keep their contents.
   always_comb begin
      main_vld_n  = main_vld;
      skid_vld_n  = skid_vld;
      main_data_n = main_data;
      skid_data_n = skid_data;
      if (flush_i) begin
         main_vld_n = 1'b0;
         skid_vld_n = 1'b0;
      end else if (SKID != 0) begin
         case ({main_vld, skid_vld})
            2'b10: begin
               if (push && !pop) begin
                  skid_vld_n  = 1'b1;
                  skid_data_n = in_data_i;
               end else if (push) begin
                  main_data_n = in_data_i;
               end else if (pop) begin
                  main_vld_n = 1'b0;
               end
            end
            2'b11: begin
               if (pop) begin
                  main_data_n = skid_data;
                  skid_vld_n  = 1'b0;
               end
            end
            default: begin
               if (push) begin
                  main_vld_n  = 1'b1;
                  main_data_n = in_data_i;
               end
            end
         endcase
      end else begin
         if (push) begin
            main_vld_n  = 1'b1;
            main_data_n = in_data_i;
         end else if (pop) begin
            main_vld_n = 1'b0;
         end
      end
   end

   always_comb begin
      out_valid_o = main_vld;
      out_data_o  = main_data;
      occupancy_o = {1'b0, main_vld} + {1'b0, skid_vld};
      if (SKID != 0) begin
         in_ready_o = rst & ~skid_vld;
      end else begin
         in_ready_o = rst & (~main_vld | out_ready_i);
      end
      push = in_valid_i & in_ready_o;
      pop  = main_vld & out_ready_i;
   end

endmodule
